// File: rtl/spi_master_shifter.sv
// SPI mode-0 master serial engine: pops words from a FWFT TX FIFO, shifts them
// out MSB-first on mosi, samples miso and pushes the received word to the RX FIFO.
module spi_master_shifter #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_empty,
  output logic             tx_pop,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_full,
  output logic             rx_push,
  output logic             busy,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, PUSH, WAIT_RX, CS_HOLD} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             div_done;
  logic             start;

  assign div_done = (div == DIV_LAST);
  assign start    = enable && !tx_empty;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      tx_pop  <= 1'b0;
      rx_push <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      tx_pop  <= 1'b0;
      rx_push <= 1'b0;
      case (state)
        IDLE: begin
          sclk    <= 1'b0;
          cs_n    <= 1'b1;
          div     <= '0;
          bit_cnt <= '0;
          if (start) begin
            tx_pop <= 1'b1;
            tx_sr  <= tx_data;
            mosi   <= tx_data[WIDTH-1];
            cs_n   <= 1'b0;
            state  <= LOW;
          end
        end
        LOW: begin
          if (div_done) begin
            div     <= '0;
            sclk    <= 1'b1;
            rx_sr   <= {rx_sr[WIDTH-2:0], miso};
            bit_cnt <= bit_cnt + CNT_W'(1);
            state   <= HIGH;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_done) begin
            div  <= '0;
            sclk <= 1'b0;
            if (bit_cnt == CNT_LAST) begin
              bit_cnt <= '0;
              state   <= PUSH;
            end else begin
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[WIDTH-2];
              state <= LOW;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        // Push waits out a full RX FIFO; sclk is already low so the bus just stalls.
        PUSH, WAIT_RX: begin
          if (!rx_full) begin
            rx_push <= 1'b1;
            rx_data <= rx_sr;
            if (start) begin
              tx_pop <= 1'b1;
              tx_sr  <= tx_data;
              mosi   <= tx_data[WIDTH-1];
              state  <= LOW;
            end else begin
              state <= CS_HOLD;
            end
          end else begin
            state <= WAIT_RX;
          end
        end
        CS_HOLD: begin
          if (div_done) begin
            div   <= '0;
            cs_n  <= 1'b1;
            state <= IDLE;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench: stimulus posts expected words/bits into scoreboard arrays, a
// negedge monitor compares every push, mosi bit and timing relation it observes.
module tb_spi_master_shifter;
  localparam int W = 8;
  localparam int DA = 2;
  localparam int DB = 1;
  localparam int LIMIT = 6000;
  localparam int P_BASIC = 1, P_B2B = 2, P_STALL = 3, P_DIS = 4, P_RST = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A (CLK_DIV=2)
  logic enable = 1'b0, rx_full = 1'b0, loop = 1'b1, miso_val = 1'b0;
  logic tx_pop, rx_push, busy, sclk, mosi, cs_n, miso, tx_empty;
  logic [W-1:0] tx_data, rx_data;
  logic [W-1:0] tx_words[64];
  logic [5:0] tx_wr = '0, tx_rd = '0;
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_data  = tx_words[tx_rd];
  assign miso     = loop ? mosi : miso_val;
  always @(posedge clk) if (tx_pop) tx_rd <= tx_rd + 6'd1;

  spi_master_shifter #(.WIDTH(W), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_empty(tx_empty),
    .tx_pop(tx_pop), .rx_data(rx_data), .rx_full(rx_full), .rx_push(rx_push),
    .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n));

  // DUT B (CLK_DIV=1), loopback
  logic b_enable = 1'b1, b_rx_full = 1'b0;
  logic b_tx_pop, b_rx_push, b_busy, b_sclk, b_mosi, b_cs_n, b_tx_empty;
  logic [W-1:0] b_tx_data, b_rx_data;
  logic [W-1:0] b_words[4];
  logic [1:0] b_wr = '0, b_rd = '0;
  assign b_tx_empty = (b_wr == b_rd);
  assign b_tx_data  = b_words[b_rd];
  always @(posedge clk) if (b_tx_pop) b_rd <= b_rd + 2'd1;

  spi_master_shifter #(.WIDTH(W), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .tx_data(b_tx_data), .tx_empty(b_tx_empty),
    .tx_pop(b_tx_pop), .rx_data(b_rx_data), .rx_full(b_rx_full), .rx_push(b_rx_push),
    .busy(b_busy), .sclk(b_sclk), .mosi(b_mosi), .miso(b_mosi), .cs_n(b_cs_n));

  // Scoreboards (single writer per index)
  logic [W-1:0] exp_q[64];
  logic [5:0] exp_wr = '0, exp_rd = '0;
  logic bit_q[256];
  logic [7:0] bit_wr = '0, bit_rd = '0;
  logic [W-1:0] b_exp_q[4];
  logic [1:0] b_exp_wr = '0, b_exp_rd = '0;

  int phase = 0;
  logic stall_chk = 1'b0, dis_chk = 1'b0, stim_done = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic queue_word(input logic [W-1:0] d, input logic [W-1:0] e,
                            input logic expect_push, input logic track_bits);
    tx_words[tx_wr] = d;
    tx_wr = tx_wr + 6'd1;
    if (expect_push) begin
      exp_q[exp_wr] = e;
      exp_wr = exp_wr + 6'd1;
    end
    if (track_bits)
      for (int i = W - 1; i >= 0; i--) begin
        bit_q[bit_wr] = d[i];
        bit_wr = bit_wr + 8'd1;
      end
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((busy || !tx_empty || !cs_n) && n < 2000) begin
      tick();
      n++;
    end
    repeat (2) tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    b_words[b_wr] = 8'h5A; b_wr = b_wr + 2'd1;
    b_exp_q[b_exp_wr] = 8'h5A; b_exp_wr = b_exp_wr + 2'd1;

    phase = P_BASIC; enable = 1'b1; loop = 1'b1;
    queue_word(8'hA5, 8'hA5, 1'b1, 1'b1);
    wait_idle();

    phase = P_B2B; loop = 1'b0; miso_val = 1'b1;
    queue_word(8'h01, 8'hFF, 1'b1, 1'b1);
    queue_word(8'h80, 8'hFF, 1'b1, 1'b1);
    queue_word(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_idle();

    phase = P_STALL; loop = 1'b1;
    queue_word(8'h96, 8'h96, 1'b1, 1'b0);
    for (int n = 0; n < 100 && !tx_pop; n++) @(negedge clk);
    tick(); rx_full = 1'b1;
    repeat (36) tick();
    stall_chk = 1'b1;
    repeat (10) tick();
    rx_full = 1'b0; stall_chk = 1'b0;
    wait_idle();

    phase = P_DIS; enable = 1'b0;
    queue_word(8'hC3, 8'hC3, 1'b1, 1'b0);
    dis_chk = 1'b1;
    repeat (20) tick();
    dis_chk = 1'b0; enable = 1'b1;
    wait_idle();

    phase = P_RST;
    queue_word(8'h77, 8'h00, 1'b0, 1'b0);
    repeat (4) @(posedge sclk);
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    queue_word(8'h3C, 8'h3C, 1'b1, 1'b0);
    wait_idle();
    stim_done = 1'b1;
  end

  // Monitor
  int cyc = 0, errors = 0, checks = 0;
  int pop_cyc = 0, push_cyc = 0, rel_cyc = 0, en_cyc = 0, b_pop_cyc = -100;
  int hi_cnt = 0, pulses = 0, b2b_pops = 0;
  logic prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_rx_full = 1'b0, prev_en = 1'b0;
  logic b_prev_sclk = 1'b0, in_frame = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_a", 32'({sclk, mosi, cs_n, tx_pop, rx_push, busy, rx_data}), 32'(14'h0800));
      chk("reset_b", 32'({b_sclk, b_mosi, b_cs_n, b_tx_pop, b_rx_push, b_busy, b_rx_data}), 32'(14'h0800));
      hi_cnt = 0; pulses = 0; in_frame = 1'b0;
    end else begin
      if (in_frame) chk("b2b_cs_low", 32'(cs_n), 32'd0);
      if (sclk && !prev_sclk) begin
        pulses++;
        if (bit_rd != bit_wr) begin
          chk("mosi_bit", 32'(mosi), 32'(bit_q[bit_rd]));
          bit_rd = bit_rd + 8'd1;
        end
      end
      if (sclk) hi_cnt++;
      else if (prev_sclk) begin
        chk("sclk_high_cycles", 32'(hi_cnt), 32'(DA));
        hi_cnt = 0;
      end
      if (rx_push) begin
        if (exp_rd == exp_wr) begin
          checks++; errors++;
          $display("FAIL unexpected_rx_push: got data %0h expected no push (cycle %0d)", rx_data, cyc);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_q[exp_rd]));
          exp_rd = exp_rd + 6'd1;
        end
        chk("rx_full_at_push", 32'(rx_full), 32'd0);
        chk("sclk_pulses", 32'(pulses), 32'(W));
        if (phase == P_STALL) chk("stall_release_latency", 32'(cyc - rel_cyc), 32'd1);
        else chk("pop_to_push_latency", 32'(cyc - pop_cyc), 32'd33);
        if (phase == P_B2B && b2b_pops == 3) in_frame = 1'b0;
        push_cyc = cyc;
      end
      if (tx_pop) begin
        chk("tx_pop_nonempty", 32'(tx_empty), 32'd0);
        if (phase == P_B2B) begin
          chk("b2b_pop_with_push", 32'(rx_push), 32'(b2b_pops > 0));
          b2b_pops++;
          in_frame = 1'b1;
        end
        if (phase == P_DIS) chk("enable_start", 32'(cyc - en_cyc), 32'd1);
        pop_cyc = cyc; pulses = 0;
      end
      if (!prev_en && enable) en_cyc = cyc;
      if (prev_rx_full && !rx_full) rel_cyc = cyc;
      if (!prev_cs_n && cs_n) begin
        chk("cs_hold_cycles", 32'(cyc - push_cyc), 32'(DA));
        chk("busy_after_frame", 32'(busy), 32'd0);
      end
      if (stall_chk) chk("wait_rx_hold", 32'({sclk, cs_n, rx_push}), 32'd0);
      if (dis_chk) chk("disabled_idle", 32'({tx_pop, cs_n, busy}), 32'(3'b010));
      if (b_tx_pop) b_pop_cyc = cyc;
      if (cyc > b_pop_cyc && cyc <= b_pop_cyc + 16)
        chk("b_sclk_toggle", 32'(b_sclk != b_prev_sclk), 32'd1);
      if (b_rx_push) begin
        if (b_exp_rd == b_exp_wr) begin
          checks++; errors++;
          $display("FAIL b_unexpected_rx_push: got data %0h expected no push (cycle %0d)", b_rx_data, cyc);
        end else begin
          chk("b_rx_data", 32'(b_rx_data), 32'(b_exp_q[b_exp_rd]));
          b_exp_rd = b_exp_rd + 2'd1;
        end
      end
    end
    prev_sclk = sclk; prev_cs_n = cs_n; prev_rx_full = rx_full;
    prev_en = enable; b_prev_sclk = b_sclk;
    if (stim_done || cyc >= LIMIT) begin
      if (!stim_done) begin
        checks++; errors++;
        $display("FAIL timeout: stimulus incomplete after %0d cycles", cyc);
      end
      chk("scoreboard_drained", 32'({exp_wr - exp_rd, b_exp_wr - b_exp_rd, bit_wr - bit_rd}), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
